// File: rtl/signal_buffer_pkg.sv
// signal_buffer_pkg
// Shared definitions for the 8192x16 signal buffer and its stream reader:
// geometry constants, reader defaults and the reader FSM state encoding.
package signal_buffer_pkg;

    localparam int SB_ADDR_W       = 13;
    localparam int SB_DATA_W       = 16;
    localparam int SB_DEPTH        = 8192;
    localparam int SB_LEN_W        = 14;
    localparam int SB_READ_LATENCY = 1;
    localparam int SB_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } sb_rd_state_e;

endpackage

// File: rtl/signal_buffer_reader_chk.sv
// signal_buffer_reader_chk
// Non-synthesised checker for the reader: rejects configurations whose skid
// FIFO cannot absorb the read pipeline, and flags any FIFO overflow.
// Ports: clk, reset_n, FIFO push/pop/clear strobes and full flag.
module signal_buffer_reader_chk
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  logic full
);

    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_cfg_check
        $error("signal_buffer_reader: FIFO_DEPTH must be >= READ_LATENCY+2");
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/signal_buffer_reader_fifo.sv
// signal_buffer_reader_fifo
// Synchronous show-ahead FIFO: rd_data always presents the oldest entry.
// Ports: clk, reset_n (sync, active-low), push/push_data, pop, clear
// (drops all contents, wins over push/pop), rd_data, count, full, empty.
// A push while full is accepted only together with a pop.
module signal_buffer_reader_fifo
#(
    parameter int W     = 18,
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0]    PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/signal_buffer_reader.sv
// signal_buffer_reader
// Avalon-MM read master that drains base_addr..base_addr+length-1 (wrapping
// modulo 2^ADDR_W) from the signal buffer and emits the words as one
// Avalon-ST packet with backpressure.
// Ports: start/abort/base_addr/length control, busy/done status, Avalon-MM
// read master (mem_*), Avalon-ST source (st_*).
module signal_buffer_reader
    import signal_buffer_pkg::*;
#(
    parameter int ADDR_W       = SB_ADDR_W,
    parameter int DATA_W       = SB_DATA_W,
    parameter int LEN_W        = SB_LEN_W,
    parameter int READ_LATENCY = SB_READ_LATENCY,
    parameter int FIFO_DEPTH   = SB_FIFO_DEPTH
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = DATA_W + 2;
    localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    sb_rd_state_e            state_r;
    sb_rd_state_e            state_s;
    logic [ADDR_W-1:0]       base_r;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        issued_r;
    logic [LEN_W-1:0]        rcv_r;
    logic [LEN_W-1:0]        beat_r;
    logic [READ_LATENCY-1:0] infl_r;
    logic                    done_r;
    logic [CNT_W-1:0]        fifo_count_s;
    logic [CNT_W-1:0]        inflight_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [FIFO_W-1:0]       push_data_s;
    logic [FIFO_W-1:0]       head_s;
    logic                    credit_ok_s;
    logic                    issue_s;
    logic                    launch_s;
    logic                    clear_s;
    logic                    done_set_s;
    logic                    push_s;
    logic                    accept_s;
    logic                    last_beat_s;

    // Number of reads still travelling through the slave pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + {{(CNT_W-1){1'b0}}, infl_r[i]};
        end
    end

    // Every issued read owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok_s = ({1'b0, fifo_count_s} + {1'b0, inflight_s}) < CREDIT_MAX;
    assign accept_s    = !fifo_empty_s && st_ready;
    assign last_beat_s = (beat_r == len_r - LEN_ONE);
    assign push_s      = infl_r[READ_LATENCY-1] && ((state_r == RUN) || (state_r == DRAIN));
    // Packet flags are attached when the word returns, by arrival order.
    assign push_data_s = {(rcv_r == '0), (rcv_r == len_r - LEN_ONE), mem_readdata};

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_s    = state_r;
        issue_s    = 1'b0;
        launch_s   = 1'b0;
        clear_s    = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    if (length != '0) begin
                        state_s  = RUN;
                        launch_s = 1'b1;
                    end else begin
                        done_set_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = FLUSH;
                    clear_s = 1'b1;
                end else if (issued_r == len_r) begin
                    state_s = DRAIN;
                end else begin
                    issue_s = credit_ok_s;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_s = FLUSH;
                    clear_s = 1'b1;
                end else if (accept_s && last_beat_s) begin
                    state_s    = IDLE;
                    done_set_s = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            FLUSH: begin
                if (inflight_s == '0) begin
                    state_s = IDLE;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer window, issue/return/beat counters and done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_r   <= '0;
            len_r    <= '0;
            issued_r <= '0;
            rcv_r    <= '0;
            beat_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= done_set_s;
            if (launch_s) begin
                base_r   <= base_addr;
                len_r    <= length;
                issued_r <= '0;
                rcv_r    <= '0;
                beat_r   <= '0;
            end else begin
                if (issue_s) begin
                    issued_r <= issued_r + LEN_ONE;
                end
                if (push_s && !clear_s) begin
                    rcv_r <= rcv_r + LEN_ONE;
                end
                if (accept_s) begin
                    beat_r <= beat_r + LEN_ONE;
                end
            end
        end
    end

    // In-flight delay line: one bit per outstanding read, matures at readdata.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            infl_r <= '0;
        end else begin
            infl_r[0] <= issue_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                infl_r[i] <= infl_r[i-1];
            end
        end
    end

    signal_buffer_reader_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (accept_s),
        .clear     (clear_s),
        .rd_data   (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    signal_buffer_reader_chk #(
        .READ_LATENCY (READ_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (accept_s),
        .clear   (clear_s),
        .full    (fifo_full_s)
    );

    assign busy           = (state_r != IDLE);
    assign done           = done_r;
    // A read launched during reset would be forgotten, so none is launched.
    assign mem_chipselect = issue_s && reset_n;
    assign mem_address    = base_r + issued_r[ADDR_W-1:0];
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_writedata  = '0;
    assign st_valid       = !fifo_empty_s;
    assign st_data        = fifo_empty_s ? '0 : head_s[DATA_W-1:0];
    assign st_sop         = !fifo_empty_s && head_s[DATA_W+1];
    assign st_eop         = !fifo_empty_s && head_s[DATA_W];

endmodule

// File: tb/tb_signal_buffer_reader.sv
// tb_signal_buffer_reader
// Directed bench for signal_buffer_reader. The memory model returns its own
// word address as data one cycle after chipselect. Stimulus pushes expected
// addresses and beats into queues; a monitor pops and compares them.
module tb_signal_buffer_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [12:0] base_addr;
    logic [13:0] length;
    logic        busy;
    logic        done;
    logic [12:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;

    int n_chk  = 0;
    int n_pass = 0;
    int n_beats = 0;
    logic [12:0] addr_q[$];
    logic [17:0] exp_q[$];
    logic        stall_r = 1'b0;
    logic [17:0] stall_v = '0;

    signal_buffer_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word[a] = a, one-cycle read latency.
    always @(posedge clk) begin
        mem_readdata <= mem_chipselect ? {3'b000, mem_address} : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [12:0] base, input int len);
        logic [12:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 13'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == 0), (i == len - 1), 3'b000, a});
        end
    endtask

    task automatic start_xfer(input logic [12:0] base, input logic [13:0] len);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        tick();
        start = 1'b0;
    endtask

    // Full-rate transfer with cycle-exact checks of the control outputs.
    task automatic run_stream(input logic [12:0] base, input int len);
        push_expect(base, len);
        start_xfer(base, 14'(len));
        for (int c = 1; c <= len + 4; c++) begin
            @(negedge clk);
            check($sformatf("cs[b%0h c%0d]", base, c), 32'(mem_chipselect), 32'(c <= len));
            check($sformatf("valid[b%0h c%0d]", base, c), 32'(st_valid),
                  32'((len != 0) && (c >= 3) && (c <= len + 2)));
            check($sformatf("done[b%0h c%0d]", base, c), 32'(done),
                  32'((len == 0) ? (c == 1) : (c == len + 3)));
            check($sformatf("busy[b%0h c%0d]", base, c), 32'(busy),
                  32'((len != 0) && (c <= len + 2)));
            tick();
        end
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("beat_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: addresses, beats and stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_chipselect) begin
                if (addr_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL addr_extra: got read of %0h expected none", mem_address);
                end else begin
                    check("addr", 32'(mem_address), 32'(addr_q.pop_front()));
                end
            end
            if (stall_r) begin
                check("stall_hold", {13'd0, st_valid, st_sop, st_eop, st_data}, {13'd0, 1'b1, stall_v});
            end
            if (st_valid && st_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL beat_extra: got beat %0h expected none", st_data);
                end else begin
                    check("beat", {14'd0, st_sop, st_eop, st_data}, {14'd0, exp_q.pop_front()});
                end
            end
            stall_r <= st_valid && !st_ready;
            stall_v <= {st_sop, st_eop, st_data};
        end
    end

    initial begin
        int  k;
        logic got_done;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        st_ready  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_st", {st_valid, st_sop, st_eop, st_data}, 32'd0);
        check("rst_const", {mem_write, mem_byteenable, mem_writedata}, 32'h0003_0000);
        reset_n = 1'b1;
        tick();

        run_stream(13'h0010, 4);
        run_stream(13'h1FFE, 4);

        // Alternating backpressure.
        push_expect(13'h0100, 8);
        start_xfer(13'h0100, 14'd8);
        got_done = 1'b0;
        for (int c = 1; c <= 60 && !got_done; c++) begin
            st_ready = c[0];
            @(negedge clk);
            got_done = done;
            tick();
        end
        st_ready = 1'b1;
        check("toggle_done", 32'(got_done), 32'd1);
        check("toggle_beats_left", 32'(exp_q.size()), 32'd0);
        check("toggle_addr_left", 32'(addr_q.size()), 32'd0);

        run_stream(13'h0055, 0);
        run_stream(13'h0777, 1);

        // abort and start together in IDLE: start is ignored.
        start = 1'b1; abort = 1'b1; base_addr = 13'h0123; length = 14'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_cs", 32'(mem_chipselect), 32'd0);
        tick();

        // Abort after 10 accepted beats.
        push_expect(13'h0200, 100);
        n_beats = 0;
        start_xfer(13'h0200, 14'd100);
        k = 0;
        while (n_beats < 10 && k < 200) begin
            tick();
            k++;
        end
        check("abort_wait_beats", 32'(n_beats), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        check("abort_cs_same", 32'(mem_chipselect), 32'd0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_next", 32'(st_valid), 32'd0);
        check("abort_done1", 32'(done), 32'd0);
        tick();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done2", 32'(done), 32'd0);
        tick();
        addr_q.delete();
        exp_q.delete();
        run_stream(13'h0300, 4);

        // Reset mid-transfer, with a start while busy beforehand.
        push_expect(13'h0400, 20);
        start_xfer(13'h0400, 14'd20);
        tick();
        start = 1'b1; base_addr = 13'h1234; length = 14'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cs", 32'(mem_chipselect), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd0);
        check("mid_rst_st", {st_valid, st_sop, st_eop, st_data}, 32'd0);
        tick();
        addr_q.delete();
        exp_q.delete();
        run_stream(13'h0500, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/signal_buffer_reader.md
# signal_buffer_reader

Avalon-MM read master that drains a programmed window of the 8192×16 dual-port signal buffer through its second slave port. It emits the samples as an Avalon-ST packet with backpressure. It sits between the signal buffer and the downstream reconstruction/DMA stream path, and is started by a control register block on the same clock.

## Interface
- ADDR_W, 13, buffer word-address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 16, sample width
- LEN_W, 14, length width; permits 1..8192 samples
- READ_LATENCY, 1, fixed slave read latency in cycles; no waitrequest
- FIFO_DEPTH, 4, output skid FIFO depth; must be ≥ READ_LATENCY+2 (parameter check)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches base_addr/length; ignored while busy
- abort  in  1  one-cycle pulse; cancels transfer
- base_addr  in  ADDR_W  first word address
- length  in  LEN_W  number of samples
- busy  out  1  high from the cycle after start until done or abort completes
- done  out  1  one-cycle pulse when the last sample is accepted
- mem_address  out  ADDR_W  read address
- mem_chipselect  out  1  read strobe, one word per cycle high
- mem_write  out  1  constant 0
- mem_byteenable  out  DATA_W/8  constant all-ones
- mem_writedata  out  DATA_W  constant 0
- mem_readdata  in  DATA_W  valid READ_LATENCY cycles after chipselect
- st_data  out  DATA_W  sample
- st_valid  out  1  sample valid
- st_ready  in  1  sink ready; ready latency 0
- st_sop / st_eop  out  1  first / last sample of packet

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: issuing reads.
  - DRAIN: all reads issued, waiting for the FIFO and in-flight reads to empty.
  - FLUSH: abort in progress.
- IDLE→RUN on start with length≠0.
- start with length=0: done pulses the next cycle, no reads, state stays IDLE.
- Issue rule in RUN: mem_chipselect=1 iff issued<length and fifo_count+inflight<FIFO_DEPTH.
  - mem_address=base_addr+issued, truncated to ADDR_W (8191 wraps to 0).
- RUN→DRAIN when issued==length.
- DRAIN→IDLE on the handshake of the eop beat; done pulses and busy clears in the following cycle.
- A delay line of depth READ_LATENCY tracks in-flight reads. When a slot matures, mem_readdata is written into the FIFO.
- The credit rule guarantees the FIFO never overflows. A FIFO overflow is an assertion failure.
- st_sop marks sample index 0; st_eop marks index length-1. length=1 sets both on the same beat.
- The beat counter advances only on st_valid&&st_ready.
- st_data and flags hold stable while st_valid&&!st_ready.
- abort (RUN/DRAIN)→FLUSH:
  - Issuing stops the same cycle.
  - The FIFO clears and st_valid drops the next cycle.
  - In-flight returns are discarded.
  - FLUSH→IDLE once inflight==0. No done pulse.
- abort in IDLE is ignored. abort and start in the same cycle: abort wins; start is ignored.
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_sop=0, st_eop=0, st_data=0. FSM=IDLE, FIFO empty, counters 0.
- Reset mid-transfer behaves as an immediate abort with no done pulse.

## Timing
- start sampled at edge T. The first mem_chipselect is in cycle T+1 with address base_addr.
- readdata is captured at the end of cycle T+1+READ_LATENCY. The first st_valid is in cycle T+2+READ_LATENCY, i.e. T+3 by default.
- With st_ready held high: one sample per cycle sustained, no bubbles.
  - Total length+3 cycles from start to the done cycle (default latency).
- st_ready low for k cycles: issuing stalls within 1 cycle of the FIFO credit running out, and resumes the cycle after a pop frees credit.
- busy rises in cycle T+1.

## Structure
- Shared package signal_buffer_pkg:
  - SB_ADDR_W=13, SB_DATA_W=16, SB_DEPTH=8192
  - reader FSM state enum (IDLE, RUN, DRAIN, FLUSH)
- Sub-module signal_buffer_reader_fifo: synchronous show-ahead FIFO, parameterised width and depth.
  - Ports: push, pop, clear, count, full, empty.
  - Data/flags stored as {sop, eop, data}.
- Top holds the FSM, issue/beat counters and the in-flight shift register.

## Test plan
- base=0x0010, length=4, memory word[i]=i, st_ready=1 → chipselect cycles 1–4, st_data 0x0010..0x0013 in cycles 3–6, sop on the first beat, eop on the last, done in cycle 7.
- base=0x1FFE, length=4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001; data order preserved; no gaps.
- length=8, st_ready toggles 1/0 each cycle → 8 beats in order, no drops or duplicates, FIFO count ≤4, data stable while stalled.
- length=0 → done pulse in cycle 1, no chipselect, no st_valid; length=1 → single beat with sop=eop=1.
- length=100, abort asserted after 10 beats accepted → chipselect low the same cycle, st_valid low the next cycle, no done, busy low within READ_LATENCY+1 cycles. A subsequent start runs cleanly.
- reset_n low for one cycle mid-transfer → all outputs at reset values on the next cycle; start while busy has no effect on address or length.
